stream_input_adapter: RTL and testbench
=======================================

// Module: stream_input_adapter
// PURPOSE
//  Ingress stage of the Dilithium accelerator. Accepts the external 64-bit valid/ready/last stream
//  and delivers it to the Dilithium core input port through a small skid FIFO. Tracks the fixed
//  per-operation prefix length (seed / sk / pk+sig) and then the variable message tail.
//  Reports framing status; the egress stream adapter is its output-side counterpart.
// PARAMETERS
//  W            64  data word width (bits)
//  FIFO_DEPTH   4   skid FIFO depth in words; power of two, >=2
//  MSG_CNT_W    16  width of the message word counter
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          1-cycle pulse: latch mode/sec_lvl, clear state, begin new frame
//  mode           in   2          0 keygen, 1 sign, 2 verify; 3 reserved (treated as keygen)
//  sec_lvl        in   3          2, 3 or 5; any other value treated as 5
//  valid_i        in   1          external word valid
//  ready_i        out  1          adapter can accept the external word
//  data_i         in   W          external word
//  last_i         in   1          external end-of-frame marker
//  core_valid_o   out  1          word available to core
//  core_ready_i   in   1          core accepts word
//  core_data_o    out  W          word to core
//  core_last_o    out  1          final word of frame
//  msg_words_o    out  MSG_CNT_W  message words accepted so far in current frame
//  busy_o         out  1          frame in progress (state FIXED or MSG, or FIFO not empty)
//  err_o          out  1          sticky framing error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; ready_i=0, core_valid_o=0, core_last_o=0, msg_words_o=0, busy_o=0, err_o=0; FIFO empty.
//  - Fixed prefix length F (words), latched on start: keygen 4; sign 316/500/608;
//    verify 467/656/899 (pk+sig, sig padded to whole words) for sec_lvl 2/3/5.
//  - FSM: IDLE -start-> FIXED. FIXED: counts accepted words; on word F: keygen -> DONE, sign/verify -> MSG.
//    MSG: each accepted word increments msg_words_o (saturates at all-ones); word with last_i -> DONE.
//    DONE -> IDLE when FIFO empty. ERR held until start or rst.
//  - Word accepted when valid_i && ready_i. ready_i = (state FIXED or MSG) && !fifo_full. No comb path valid_i->ready_i.
//  - FIFO entry = {last, data}. last bit set on the frame's final word (keygen word 4, or last_i word in MSG).
//    core_valid_o = !fifo_empty; core_data_o/core_last_o = FIFO head. Pop on core_valid_o && core_ready_i.
//  - Latency: word accepted in cycle n is visible on core_data_o in cycle n+1 (registered FIFO write).
//  - Simultaneous push and pop when full: pop proceeds; push blocked (ready_i is 0 that cycle).
//  - Sign/verify with zero-length message is impossible: last_i must arrive in MSG on >=1 word.
//  - start mid-frame: FIFO flushed, counters cleared, err_o cleared, new mode/sec_lvl latched, state FIXED next cycle.
//  - start while rst: rst wins.
// CONFIGURATION
//  STREAM_IN_FRAME_CHECK_EN defined: last_i asserted during FIXED, or keygen word 4 without last_i,
//    sets err_o, moves to ERR; the offending word is dropped; ready_i=1 in ERR (drain and discard input).
//  Not defined: last_i ignored in FIXED (keygen ends on word 4 regardless); err_o tied 0; ERR unreachable.
// STRUCTURE
//  - Package dilithium_stream_pkg: mode_t enum (MODE_KEYGEN, MODE_SIGN, MODE_VERIFY), in_state_t enum,
//    function fixed_in_words(mode_t, logic[2:0]) returning F, width constant FIXED_CNT_W=10.
//  - One sub-module: skid_fifo (WIDTH=W+1, DEPTH=FIFO_DEPTH, registered-output, full/empty flags).
// TESTING
//  1 keygen sec5: start, 4 words, last on word 4 -> 4 core words, core_last_o on 4th only, err_o=0, back to IDLE.
//  2 sign sec2, msg 3 words, last on 3rd -> 319 core words in order, msg_words_o=3, core_last_o on word 319.
//  3 verify sec3, core_ready_i toggled 1/0 random -> no loss/dup, ready_i drops while FIFO holds 4.
//  4 FRAME_CHECK_EN: sign sec3, last_i on word 10 -> err_o=1 next cycle, ERR, no further core words.
//  5 start at word 200 of verify sec5 -> FIFO empty, msg_words_o=0, new frame completes normally.
//  6 rst during MSG -> all outputs at reset values next cycle; IDLE, ready_i=0.

Source files
------------

// File: rtl/dilithium_stream_pkg.sv
// Shared types and helpers for the Dilithium stream adapters.
// Holds the operation modes, ingress FSM states and the fixed-prefix length table.
package dilithium_stream_pkg;

    localparam int FIXED_CNT_W = 10;

    typedef enum logic [1:0] {
        MODE_KEYGEN = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_VERIFY = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        IN_IDLE,
        IN_FIXED,
        IN_MSG,
        IN_DONE,
        IN_ERR
    } in_state_t;

    // Prefix words before the message tail; unknown security levels fall back to level 5.
    // Verify counts pk plus the signature padded up to whole words.
    function automatic logic [FIXED_CNT_W-1:0] fixed_in_words(input mode_t mode,
                                                              input logic [2:0] sec_lvl);
        logic [FIXED_CNT_W-1:0] f;
        case (mode)
            MODE_SIGN: begin
                case (sec_lvl)
                    3'd2:    f = 10'd316;
                    3'd3:    f = 10'd500;
                    default: f = 10'd608;
                endcase
            end
            MODE_VERIFY: begin
                case (sec_lvl)
                    3'd2:    f = 10'd467;
                    3'd3:    f = 10'd656;
                    default: f = 10'd899;
                endcase
            end
            default: f = 10'd4;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/stream_input_adapter_skid_fifo.sv
// Small power-of-two FIFO between the external stream and the core input port.
// A word written in one cycle is readable at the head from the next cycle on.
module skid_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/stream_input_adapter.sv
// Ingress stage of the Dilithium accelerator: frames the external word stream into the core.
// Build option STREAM_IN_FRAME_CHECK_EN enables framing-error detection and the ERR drain state.
module stream_input_adapter
    import dilithium_stream_pkg::*;
#(
    parameter int W          = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int MSG_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [2:0]           sec_lvl,
    input  logic                 valid_i,
    output logic                 ready_i,
    input  logic [W-1:0]         data_i,
    input  logic                 last_i,
    output logic                 core_valid_o,
    input  logic                 core_ready_i,
    output logic [W-1:0]         core_data_o,
    output logic                 core_last_o,
    output logic [MSG_CNT_W-1:0] msg_words_o,
    output logic                 busy_o,
    output logic                 err_o
);

    in_state_t              state;
    in_state_t              state_next;
    mode_t                  mode_q;
    mode_t                  start_mode;
    logic [FIXED_CNT_W-1:0] fixed_len;
    logic [FIXED_CNT_W-1:0] fixed_cnt;
    logic [MSG_CNT_W-1:0]   msg_cnt;
    logic                   accept;
    logic                   last_fixed;
    logic                   frame_bad;
    logic                   push;
    logic                   push_last;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [W:0]             fifo_head;

    // Reserved mode encoding runs as keygen.
    always_comb begin
        case (mode)
            2'd1:    start_mode = MODE_SIGN;
            2'd2:    start_mode = MODE_VERIFY;
            default: start_mode = MODE_KEYGEN;
        endcase
    end

    assign accept     = valid_i && ready_i;
    assign last_fixed = (fixed_cnt == fixed_len - 1'b1);
    assign pop        = core_valid_o && core_ready_i;

`ifdef STREAM_IN_FRAME_CHECK_EN
    // Keygen must end exactly on its final prefix word; sign/verify never end inside the prefix.
    assign frame_bad = (state == IN_FIXED) &&
                       ((mode_q == MODE_KEYGEN && last_fixed) ? !last_i : last_i);
    assign ready_i   = ((state == IN_FIXED || state == IN_MSG) && !fifo_full) || (state == IN_ERR);
`else
    assign frame_bad = 1'b0;
    assign ready_i   = (state == IN_FIXED || state == IN_MSG) && !fifo_full;
`endif

    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_last  = 1'b0;
        case (state)
            IN_FIXED: begin
                if (accept) begin
                    if (frame_bad) begin
                        state_next = IN_ERR;
                    end else begin
                        push      = 1'b1;
                        push_last = (mode_q == MODE_KEYGEN) && last_fixed;
                        if (last_fixed) state_next = (mode_q == MODE_KEYGEN) ? IN_DONE : IN_MSG;
                    end
                end
            end
            IN_MSG: begin
                if (accept) begin
                    push      = 1'b1;
                    push_last = last_i;
                    if (last_i) state_next = IN_DONE;
                end
            end
            IN_DONE: begin
                if (fifo_empty) state_next = IN_IDLE;
            end
            default: begin
                state_next = state;
            end
        endcase
        // A new frame discards whatever the current cycle would have pushed.
        if (start) begin
            state_next = IN_FIXED;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IN_IDLE;
            mode_q    <= MODE_KEYGEN;
            fixed_len <= '0;
            fixed_cnt <= '0;
            msg_cnt   <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                mode_q    <= start_mode;
                fixed_len <= fixed_in_words(start_mode, sec_lvl);
                fixed_cnt <= '0;
                msg_cnt   <= '0;
            end else if (accept) begin
                if (state == IN_FIXED && !frame_bad) fixed_cnt <= fixed_cnt + 1'b1;
                if (state == IN_MSG && msg_cnt != {MSG_CNT_W{1'b1}}) msg_cnt <= msg_cnt + 1'b1;
            end
        end
    end

`ifdef STREAM_IN_FRAME_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst || start) err_q <= 1'b0;
        else if (accept && frame_bad) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    skid_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .push      (push),
        .push_data ({push_last, data_i}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign core_valid_o = !fifo_empty;
    assign core_last_o  = fifo_head[W];
    assign core_data_o  = fifo_head[W-1:0];
    assign msg_words_o  = msg_cnt;
    assign busy_o       = (state == IN_FIXED) || (state == IN_MSG) || !fifo_empty;

endmodule

// File: tb/tb_stream_input_adapter.sv
// Directed self-checking bench for stream_input_adapter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_stream_input_adapter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  sec_lvl;
    logic        valid_i;
    logic        ready_i;
    logic [63:0] data_i;
    logic        last_i;
    logic        core_valid_o;
    logic        core_ready_i;
    logic [63:0] core_data_o;
    logic        core_last_o;
    logic [15:0] msg_words_o;
    logic        busy_o;
    logic        err_o;

    int          checks;
    int          errors;
    logic [64:0] rx_q[$];
    logic        bp_random;
    logic        core_ready_fixed;

    stream_input_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .sec_lvl      (sec_lvl),
        .valid_i      (valid_i),
        .ready_i      (ready_i),
        .data_i       (data_i),
        .last_i       (last_i),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_data_o  (core_data_o),
        .core_last_o  (core_last_o),
        .msg_words_o  (msg_words_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core-side ready: either a fixed level or a random toggle each cycle.
    initial begin
        core_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            core_ready_i = bp_random ? 1'($urandom_range(0, 1)) : core_ready_fixed;
        end
    end

    // Record every word the core takes, as {last, data}.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !start && core_valid_o && core_ready_i)
                rx_q.push_back({core_last_o, core_data_o});
        end
    end

    function automatic logic [63:0] exp_word(input logic [15:0] tag, input int k);
        return {tag, 16'h0000, 32'(k)};
    endfunction

    task automatic do_start(input logic [1:0] m, input logic [2:0] l);
        @(posedge clk);
        #1;
        start   = 1'b1;
        mode    = m;
        sec_lvl = l;
        rx_q.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        int n;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        n       = 0;
        @(negedge clk);
        while (!ready_i && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready_i) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout word %h ready_i=%b required 1", d, ready_i);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        @(negedge clk);
        for (int i = 0; i < 3000 && busy_o; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready_i, core_valid_o, core_last_o, busy_o, err_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b required 00000",
                     {ready_i, core_valid_o, core_last_o, busy_o, err_o});
        end
        checks++;
        if (msg_words_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_msg_words got %0d required 0", msg_words_o);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_i !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_ready got %b required 0", ready_i);
        end
    endtask

    task automatic test_keygen();
        logic [64:0] want;
        core_ready_fixed = 1'b1;
        do_start(2'd0, 3'd5);
        for (int i = 1; i <= 4; i++) send_word(exp_word(16'h4E01, i), i == 4);
        wait_drain();
        checks++;
        if (rx_q.size() !== 4) begin
            errors++;
            $display("[TB] FAIL keygen_count got %0d required 4", rx_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < 4; k++) begin
            want = {k == 3, exp_word(16'h4E01, k + 1)};
            checks++;
            if (rx_q[k] !== want) begin
                errors++;
                $display("[TB] FAIL keygen_word%0d got %h required %h", k + 1, rx_q[k], want);
            end
        end
        checks++;
        if ({err_o, busy_o, ready_i} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL keygen_idle err/busy/ready got %b required 000",
                     {err_o, busy_o, ready_i});
        end
    endtask

    task automatic test_sign();
        logic [64:0] want;
        core_ready_fixed = 1'b1;
        do_start(2'd1, 3'd2);
        for (int i = 1; i <= 319; i++) send_word(exp_word(16'h5192, i), i == 319);
        wait_drain();
        checks++;
        if (rx_q.size() !== 319) begin
            errors++;
            $display("[TB] FAIL sign_count got %0d required 319", rx_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < 319; k++) begin
            want = {k == 318, exp_word(16'h5192, k + 1)};
            checks++;
            if (rx_q[k] !== want) begin
                errors++;
                $display("[TB] FAIL sign_word%0d got %h required %h", k + 1, rx_q[k], want);
            end
        end
        checks++;
        if (msg_words_o !== 16'd3) begin
            errors++;
            $display("[TB] FAIL sign_msg_words got %0d required 3", msg_words_o);
        end
    endtask

    task automatic test_verify_backpressure();
        logic [64:0] want;
        core_ready_fixed = 1'b0;
        do_start(2'd2, 3'd3);
        for (int i = 1; i <= 4; i++) send_word(exp_word(16'h7E53, i), 1'b0);
        @(negedge clk);
        checks++;
        if ({ready_i, core_valid_o} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL verify_full ready/core_valid got %b required 01",
                     {ready_i, core_valid_o});
        end
        bp_random = 1'b1;
        for (int i = 5; i <= 658; i++) send_word(exp_word(16'h7E53, i), i == 658);
        bp_random        = 1'b0;
        core_ready_fixed = 1'b1;
        wait_drain();
        checks++;
        if (rx_q.size() !== 658) begin
            errors++;
            $display("[TB] FAIL verify_count got %0d required 658", rx_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < 658; k++) begin
            want = {k == 657, exp_word(16'h7E53, k + 1)};
            checks++;
            if (rx_q[k] !== want) begin
                errors++;
                $display("[TB] FAIL verify_word%0d got %h required %h", k + 1, rx_q[k], want);
            end
        end
        checks++;
        if (msg_words_o !== 16'd2) begin
            errors++;
            $display("[TB] FAIL verify_msg_words got %0d required 2", msg_words_o);
        end
    endtask

`ifdef STREAM_IN_FRAME_CHECK_EN
    task automatic test_frame_error();
        core_ready_fixed = 1'b1;
        do_start(2'd1, 3'd3);
        for (int i = 1; i <= 10; i++) send_word(exp_word(16'hE220, i), i == 10);
        checks++;
        if ({err_o, ready_i} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL frame_err err/ready got %b required 11", {err_o, ready_i});
        end
        for (int i = 11; i <= 14; i++) send_word(exp_word(16'hE220, i), 1'b0);
        wait_drain();
        checks++;
        if (rx_q.size() !== 9) begin
            errors++;
            $display("[TB] FAIL frame_err_count got %0d required 9", rx_q.size());
        end
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_err_sticky got %b required 1", err_o);
        end
    endtask
`else
    task automatic test_frame_error();
        logic [64:0] want;
        core_ready_fixed = 1'b1;
        do_start(2'd0, 3'd2);
        for (int i = 1; i <= 4; i++) send_word(exp_word(16'h0B22, i), i == 2);
        wait_drain();
        checks++;
        if (rx_q.size() !== 4) begin
            errors++;
            $display("[TB] FAIL nocheck_count got %0d required 4", rx_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < 4; k++) begin
            want = {k == 3, exp_word(16'h0B22, k + 1)};
            checks++;
            if (rx_q[k] !== want) begin
                errors++;
                $display("[TB] FAIL nocheck_word%0d got %h required %h", k + 1, rx_q[k], want);
            end
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nocheck_err got %b required 0", err_o);
        end
    endtask
`endif

    task automatic test_restart();
        logic [64:0] want;
        core_ready_fixed = 1'b1;
        do_start(2'd2, 3'd5);
        for (int i = 1; i <= 200; i++) send_word(exp_word(16'h3A55, i), 1'b0);
        core_ready_fixed = 1'b0;
        for (int i = 201; i <= 202; i++) send_word(exp_word(16'h3A55, i), 1'b0);
        @(negedge clk);
        checks++;
        if (core_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_prefill core_valid got %b required 1", core_valid_o);
        end
        do_start(2'd0, 3'd2);
        checks++;
        if ({core_valid_o, ready_i, busy_o} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL restart_flush core_valid/ready/busy got %b required 011",
                     {core_valid_o, ready_i, busy_o});
        end
        checks++;
        if (msg_words_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL restart_msg_words got %0d required 0", msg_words_o);
        end
        core_ready_fixed = 1'b1;
        for (int i = 1; i <= 4; i++) send_word(exp_word(16'h3B02, i), i == 4);
        wait_drain();
        checks++;
        if (rx_q.size() !== 4) begin
            errors++;
            $display("[TB] FAIL restart_count got %0d required 4", rx_q.size());
        end
        for (int k = 0; k < rx_q.size() && k < 4; k++) begin
            want = {k == 3, exp_word(16'h3B02, k + 1)};
            checks++;
            if (rx_q[k] !== want) begin
                errors++;
                $display("[TB] FAIL restart_word%0d got %h required %h", k + 1, rx_q[k], want);
            end
        end
    endtask

    task automatic test_reset_mid_msg();
        core_ready_fixed = 1'b1;
        do_start(2'd1, 3'd2);
        for (int i = 1; i <= 318; i++) send_word(exp_word(16'h6D60, i), 1'b0);
        checks++;
        if (msg_words_o !== 16'd2) begin
            errors++;
            $display("[TB] FAIL midmsg_words got %0d required 2", msg_words_o);
        end
        core_ready_fixed = 1'b0;
        send_word(exp_word(16'h6D60, 319), 1'b0);
        @(negedge clk);
        checks++;
        if ({core_valid_o, busy_o} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midmsg_pending core_valid/busy got %b required 11",
                     {core_valid_o, busy_o});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready_i, core_valid_o, core_last_o, busy_o, err_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL midmsg_reset_flags got %b required 00000",
                     {ready_i, core_valid_o, core_last_o, busy_o, err_o});
        end
        checks++;
        if (msg_words_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midmsg_reset_words got %0d required 0", msg_words_o);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready_i, busy_o} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midmsg_idle ready/busy got %b required 00", {ready_i, busy_o});
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        start            = 1'b0;
        mode             = 2'd0;
        sec_lvl          = 3'd2;
        valid_i          = 1'b0;
        data_i           = '0;
        last_i           = 1'b0;
        bp_random        = 1'b0;
        core_ready_fixed = 1'b0;
        $display("[TB] stream_input_adapter bench start");
        test_reset();
        test_keygen();
        test_sign();
        test_verify_backpressure();
        test_frame_error();
        test_restart();
        test_reset_mid_msg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
